fft_stage_sequencer: RTL and testbench
======================================

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter NUMSTAGES, default 8: log2 of FFT size (256 points); counter width is NUMSTAGES-2.
REQ-002 Parameter NUMPASSES, default 5: number of compute passes; stage_num_r values 0..NUMPASSES-1.
REQ-003 Parameter PIPE_LAT, default 4: butterfly pipeline latency in cycles, from read to write-back.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin a transform; sampled only in IDLE.
REQ-007 in_valid  in  1  load beat present (4 samples, one per bank).
REQ-008 in_ready  out  1  sequencer accepts load beats.
REQ-009 out_ready  in  1  downstream accepts unload beat.
REQ-010 out_valid  out  1  unload beat presented.
REQ-011 counter_r  out  NUMSTAGES-2  read-side address counter for address_control.
REQ-012 wr_counter_r  out  NUMSTAGES-2  counter_r delayed PIPE_LAT cycles, for write-back addressing.
REQ-013 stage_num_r  out  3  current pass; NUMPASSES during UNLOAD.
REQ-014 rd_en, wr_en  out  1 each  compute read strobe; write-back strobe (rd_en delayed PIPE_LAT).
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  single-cycle pulse at transform completion.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.
REQ-018 IDLE: start=1 -> LOAD, counter_r=0, stage_num_r=0; start SHALL be ignored in all other states.
REQ-019 LOAD: in_ready=1; counter_r increments only on in_valid; in_valid at counter_r=all-ones -> COMPUTE, counter_r wraps to 0.
REQ-020 COMPUTE: rd_en=1 every cycle, counter_r increments unconditionally; at all-ones -> DRAIN, counter_r wraps to 0.
REQ-021 DRAIN: rd_en=0 for exactly PIPE_LAT cycles, letting wr_en complete the pass's final writes.
REQ-022 DRAIN exit: stage_num_r<NUMPASSES-1 -> stage_num_r+1, COMPUTE; else stage_num_r=NUMPASSES, UNLOAD.
REQ-023 wr_en/wr_counter_r SHALL equal rd_en/counter_r exactly PIPE_LAT cycles earlier; exactly 2^(NUMSTAGES-2) wr_en pulses per pass.
REQ-024 UNLOAD: out_valid=1; counter_r increments only on out_ready; out_ready at all-ones -> IDLE, done=1 one cycle, stage_num_r=0.
REQ-025 out_valid low with out_ready high SHALL not advance counter_r; LOAD stalls indefinitely without in_valid.
REQ-026 Counter arithmetic SHALL be modulo 2^(NUMSTAGES-2); no overflow flag.
REQ-027 Compute latency from last load beat to first out_valid SHALL be NUMPASSES*(2^(NUMSTAGES-2)+PIPE_LAT)+1 cycles.

Reset
REQ-028 rst=1 SHALL force IDLE, counter_r=0, wr_counter_r=0, stage_num_r=0, and in_ready, out_valid, rd_en, wr_en, busy, done all 0; the delay line SHALL clear.
REQ-029 Reset mid-transform SHALL abort without a done pulse; rst dominates start when both are high in the same cycle.

Structure
REQ-030 NUMSTAGES, NUMPASSES, PIPE_LAT defaults and FSM state encodings SHALL reside in shared package fft_pkg.
REQ-031 The PIPE_LAT delay of {rd_en, counter_r} SHALL be a sub-module fft_delay_line (parameterised width/depth, sync clear).

Verification
REQ-032 Reset then start, in_valid held 1 -> 64 in_ready beats, COMPUTE entered on cycle after 64th beat with counter_r=0.
REQ-033 Full run, out_ready=1 -> 5 passes of 64 rd_en and 64 wr_en each, stage_num_r 0..4 then 5, one done pulse, busy low afterward.
REQ-034 in_valid toggled every other cycle in LOAD -> counter_r advances only on beats; 128 cycles to reach COMPUTE.
REQ-035 out_ready deasserted for 10 cycles mid-UNLOAD at counter_r=20 -> counter_r holds 20, out_valid stays 1.
REQ-036 rst asserted during pass 2 COMPUTE at counter_r=30 -> next cycle all outputs 0, IDLE, no done; fresh start runs normally.
REQ-037 start pulsed during COMPUTE -> no state change; wr_en lags rd_en by exactly 4 cycles throughout.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults and state encoding for the FFT stage sequencer
package fft_pkg;

  localparam int NUMSTAGES_DEF = 8;
  localparam int NUMPASSES_DEF = 5;
  localparam int PIPE_LAT_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_UNLOAD  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - fixed-depth shift register with synchronous clear
module fft_delay_line #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - load / multi-pass compute / unload sequencer for an in-place radix-4 FFT
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int NUMSTAGES = NUMSTAGES_DEF,
  parameter int NUMPASSES = NUMPASSES_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [NUMSTAGES-3:0] counter_r,
  output logic [NUMSTAGES-3:0] wr_counter_r,
  output logic [2:0]           stage_num_r,
  output logic                 rd_en,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = NUMSTAGES - 2;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [DW-1:0] DLAST = DW'(PIPE_LAT - 1);

  seq_state_t      state;
  logic [DW-1:0]   drain_cnt;
  logic [CW:0]     dl_out;

  // All outputs are registered and updated on the same edge as the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      counter_r   <= '0;
      stage_num_r <= '0;
      drain_cnt   <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LOAD;
            counter_r   <= '0;
            stage_num_r <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            counter_r <= counter_r + 1'b1;
            if (counter_r == CMAX) begin
              state    <= ST_COMPUTE;
              in_ready <= 1'b0;
              rd_en    <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          counter_r <= counter_r + 1'b1;
          if (counter_r == CMAX) begin
            state     <= ST_DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          // Hold off reads until the pipeline has written back this pass.
          if (drain_cnt == DLAST) begin
            if (stage_num_r < 3'(NUMPASSES - 1)) begin
              stage_num_r <= stage_num_r + 1'b1;
              state       <= ST_COMPUTE;
              rd_en       <= 1'b1;
            end else begin
              stage_num_r <= 3'(NUMPASSES);
              state       <= ST_UNLOAD;
              out_valid   <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            counter_r <= counter_r + 1'b1;
            if (counter_r == CMAX) begin
              state       <= ST_IDLE;
              out_valid   <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              stage_num_r <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fft_delay_line #(
    .WIDTH (CW + 1),
    .DEPTH (PIPE_LAT)
  ) u_wr_delay (
    .clk  (clk),
    .clr  (rst),
    .din  ({rd_en, counter_r}),
    .dout (dl_out)
  );

  assign wr_en        = dl_out[CW];
  assign wr_counter_r = dl_out[CW-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

  localparam int NS       = 8;
  localparam int NP       = 5;
  localparam int PL       = 4;
  localparam int N        = 1 << (NS - 2);
  localparam int PASS_LEN = N + PL;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic          in_ready, out_valid, rd_en, wr_en, busy, done;
  logic [NS-3:0] counter_r, wr_counter_r;
  logic [2:0]    stage_num_r;

  int n_cmp = 0;
  int n_bad = 0;

  fft_stage_sequencer #(.NUMSTAGES(NS), .NUMPASSES(NP), .PIPE_LAT(PL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .counter_r    (counter_r),
    .wr_counter_r (wr_counter_r),
    .stage_num_r  (stage_num_r),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int ir, input int ov, input int rd,
                          input int bz, input int dn, input int ctr, input int stg);
    chk({tag, ".in_ready"},  int'(in_ready),    ir);
    chk({tag, ".out_valid"}, int'(out_valid),   ov);
    chk({tag, ".rd_en"},     int'(rd_en),       rd);
    chk({tag, ".busy"},      int'(busy),        bz);
    chk({tag, ".done"},      int'(done),        dn);
    chk({tag, ".counter"},   int'(counter_r),   ctr);
    chk({tag, ".stage"},     int'(stage_num_r), stg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // iv_mode: 0 always, 1 alternate, 2 random; or_mode: 0 always, 1 stall at beat 20, 2 random
  task automatic run_transform(input int iv_mode, input int or_mode,
                               input int abort_pass, input int abort_ctr);
    int beats, cyc, ub, hold, dones, pass, off, e_rd, e_ctr, e_wr;
    int rd_cnt[NP];
    int wr_cnt[NP];
    int hist_rd[$];
    int hist_ctr[$];
    for (int p = 0; p < NP; p++) begin rd_cnt[p] = 0; wr_cnt[p] = 0; end

    start = 1'b1; in_valid = 1'b0; out_ready = 1'($urandom % 2);
    tick();
    start = 1'b0;
    chk_outs("start", 1, 0, 0, 1, 0, 0, 0);

    beats = 0; cyc = 0;
    while (beats < N && cyc < 1000) begin
      case (iv_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = 1'(cyc % 2);
        default: in_valid = ($urandom % 3) != 0;
      endcase
      start = 1'($urandom % 2); out_ready = 1'($urandom % 2);
      tick(); cyc++;
      if (in_valid) beats++;
      if (beats < N) chk_outs("load", 1, 0, 0, 1, 0, beats, 0);
    end
    chk("load_beats", beats, N);
    if (beats != N) return;
    if (iv_mode == 0) chk("load_cycles", cyc, N);
    if (iv_mode == 1) chk("load_cycles", cyc, 2 * N);

    // Expected compute timeline derived from elapsed cycles since the last load beat.
    for (int pos = 0; pos < NP * PASS_LEN; pos++) begin
      if (pos > 0) begin
        start = 1'($urandom % 2); in_valid = 1'($urandom % 2); out_ready = 1'($urandom % 2);
        tick();
      end
      pass  = pos / PASS_LEN;
      off   = pos % PASS_LEN;
      e_rd  = (off < N) ? 1 : 0;
      e_ctr = (off < N) ? off : 0;
      chk_outs("compute", 0, 0, e_rd, 1, 0, e_ctr, pass);
      hist_rd.push_back(e_rd);
      hist_ctr.push_back(e_ctr);
      e_wr = (pos >= PL) ? hist_rd[pos-PL] : 0;
      chk("wr_en", int'(wr_en), e_wr);
      if (e_wr == 1) chk("wr_counter", int'(wr_counter_r), hist_ctr[pos-PL]);
      if (rd_en) rd_cnt[pass]++;
      if (wr_en) wr_cnt[pass]++;
      if (pass == abort_pass && e_rd == 1 && e_ctr == abort_ctr) begin
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_outs("abort", 0, 0, 0, 0, 0, 0, 0);
        chk("abort.wr_en", int'(wr_en), 0);
        chk("abort.wr_counter", int'(wr_counter_r), 0);
        tick();
        chk_outs("after_abort", 0, 0, 0, 0, 0, 0, 0);
        chk("after_abort.wr_en", int'(wr_en), 0);
        return;
      end
    end
    for (int p = 0; p < NP; p++) begin
      chk("rd_pulses", rd_cnt[p], N);
      chk("wr_pulses", wr_cnt[p], N);
    end

    start = 1'($urandom % 2); out_ready = 1'b0;
    tick();
    chk_outs("unload_entry", 0, 1, 0, 1, 0, 0, NP);

    ub = 0; hold = 0; dones = 0; cyc = 0;
    while (ub < N && cyc < 2000) begin
      case (or_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = !(ub == 20 && hold < 10);
          if (!out_ready) hold++;
        end
        default: out_ready = 1'($urandom % 2);
      endcase
      start = 1'($urandom % 2); in_valid = 1'($urandom % 2);
      tick(); cyc++;
      if (out_ready) ub++;
      if (done) dones++;
      chk("unload.wr_en", int'(wr_en), 0);
      if (ub < N) chk_outs("unload", 0, 1, 0, 1, 0, ub, NP);
      else        chk_outs("finish", 0, 0, 0, 0, 1, 0, 0);
    end
    chk("unload_beats", ub, N);
    if (or_mode == 1) chk("stall_cycles", hold, 10);

    start = 1'b0; out_ready = 1'b1;
    tick();
    if (done) dones++;
    chk_outs("idle", 0, 0, 0, 0, 0, 0, 0);
    chk("done_pulses", dones, 1);
  endtask

  typedef struct {
    logic rst, start, in_valid, out_ready;
    int   e_ir, e_ov, e_rd, e_busy, e_done, e_ctr, e_stg;
  } vec_t;

  vec_t vt[10];

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1, 0, 0, 0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 1, 0, 0, 0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 0, 1, 0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1, 0, 1, 0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 0, 2, 0};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    vt[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    repeat (2) tick();

    for (int i = 0; i < 10; i++) begin
      rst = vt[i].rst; start = vt[i].start; in_valid = vt[i].in_valid; out_ready = vt[i].out_ready;
      tick();
      chk_outs($sformatf("vec%0d", i), vt[i].e_ir, vt[i].e_ov, vt[i].e_rd,
               vt[i].e_busy, vt[i].e_done, vt[i].e_ctr, vt[i].e_stg);
      chk($sformatf("vec%0d.wr_en", i), int'(wr_en), 0);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    run_transform(0, 0, -1, -1);
    run_transform(1, 1, -1, -1);
    run_transform(2, 2, 2, 30);
    run_transform(2, 2, -1, -1);
    run_transform(0, 1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
